branch_dispatch: RTL

BRANCH_DISPATCH -- requirements
Module: branch_dispatch

---
 rtl/branch_dispatch.sv | 171 +++++++++++++++++
 1 files changed

// File: rtl/branch_dispatch.sv
// Branch dispatch: queues decoded branch/jump instructions, allocates a ROB entry,
// reads and snoops operands, and issues one instruction at a time to the branch unit.
module branch_dispatch #(
    parameter logic [5:0]  INVALID_TAG = 6'b010000,
    parameter int unsigned DEPTH       = 4
) (
    input  logic        clock,
    input  logic        rst_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [6:0]  in_op,
    input  logic [2:0]  in_subtype,
    input  logic        in_flag,
    input  logic [4:0]  in_rs1,
    input  logic [4:0]  in_rs2,
    input  logic [31:0] in_offset,
    output logic [4:0]  rf_addr1,
    output logic [4:0]  rf_addr2,
    input  logic [31:0] rf_data1,
    input  logic [31:0] rf_data2,
    input  logic [5:0]  rf_tag1,
    input  logic [5:0]  rf_tag2,
    output logic        rob_alloc_req,
    input  logic        rob_alloc_gnt,
    input  logic [5:0]  rob_alloc_num,
    input  logic        CDBiscast,
    input  logic [5:0]  CDBrobNum,
    input  logic [31:0] CDBdata,
    input  logic        CDBiscast2,
    input  logic [5:0]  CDBrobNum2,
    input  logic [31:0] CDBdata2,
    input  logic        available,
    output logic        funcUnitEnable,
    output logic [6:0]  operatorType,
    output logic [2:0]  operatorSubType,
    output logic        operatorFlag,
    output logic [5:0]  robNum,
    output logic [31:0] data1,
    output logic [31:0] data2,
    output logic [5:0]  q1,
    output logic [5:0]  q2,
    output logic [31:0] offset_out
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] PTR_ONE = 1;
    localparam logic [6:0] OP_BR   = 7'b1100011;
    localparam logic [6:0] OP_JAL  = 7'b1101111;
    localparam logic [6:0] OP_JALR = 7'b1100111;

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_ALLOC = 3'd1;
    localparam logic [2:0] S_READ  = 3'd2;
    localparam logic [2:0] S_WAIT  = 3'd3;
    localparam logic [2:0] S_FIRE  = 3'd4;

    typedef struct packed {
        logic [6:0]  op;
        logic [2:0]  subtype;
        logic        flag;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [31:0] offset;
    } entry_t;

    entry_t      fifo [DEPTH];
    entry_t      head;
    logic [AW:0] wr_ptr, rd_ptr;
    logic        full, empty, push;
    logic [2:0]  state;
    logic [5:0]  rob_q;
    logic [5:0]  opd_tag1, opd_tag2;
    logic [31:0] opd_data1, opd_data2;
    logic [37:0] src1, src2, nxt1, nxt2;
    logic        use1, use2;

    // Port 2 is checked first so it wins when both broadcasts match.
    function automatic logic [37:0] snoop(input logic [5:0] tag, input logic [31:0] data,
                                          input logic c1, input logic [5:0] n1, input logic [31:0] d1,
                                          input logic c2, input logic [5:0] n2, input logic [31:0] d2);
        if (tag != INVALID_TAG && c2 && n2 == tag) return {INVALID_TAG, d2};
        if (tag != INVALID_TAG && c1 && n1 == tag) return {INVALID_TAG, d1};
        return {tag, data};
    endfunction

    assign empty = (wr_ptr == rd_ptr);
    assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign in_ready = !full;
    assign push = in_valid && in_ready && (in_op inside {OP_BR, OP_JAL, OP_JALR});

    assign rob_alloc_req  = (state == S_ALLOC);
    assign funcUnitEnable = (state == S_FIRE);

    always_comb begin
        head = fifo[rd_ptr[AW-1:0]];
        rf_addr1 = (state == S_READ) ? head.rs1 : 5'd0;
        rf_addr2 = (state == S_READ) ? head.rs2 : 5'd0;
        // JAL reads nothing, JALR only rs1; x0 is always a ready zero.
        use1 = (head.op != OP_JAL) && (head.rs1 != 5'd0);
        use2 = (head.op == OP_BR)  && (head.rs2 != 5'd0);
        src1 = {opd_tag1, opd_data1};
        src2 = {opd_tag2, opd_data2};
        if (state == S_READ) begin
            src1 = use1 ? {rf_tag1, rf_data1} : {INVALID_TAG, 32'd0};
            src2 = use2 ? {rf_tag2, rf_data2} : {INVALID_TAG, 32'd0};
        end
        nxt1 = snoop(src1[37:32], src1[31:0], CDBiscast, CDBrobNum, CDBdata,
                     CDBiscast2, CDBrobNum2, CDBdata2);
        nxt2 = snoop(src2[37:32], src2[31:0], CDBiscast, CDBrobNum, CDBdata,
                     CDBiscast2, CDBrobNum2, CDBdata2);
    end

    always_ff @(posedge clock) begin
        if (push) fifo[wr_ptr[AW-1:0]] <= '{in_op, in_subtype, in_flag, in_rs1, in_rs2, in_offset};
    end

    always_ff @(posedge clock or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr          <= '0;
            rd_ptr          <= '0;
            state           <= S_IDLE;
            rob_q           <= '0;
            opd_tag1        <= INVALID_TAG;
            opd_tag2        <= INVALID_TAG;
            opd_data1       <= '0;
            opd_data2       <= '0;
            operatorType    <= '0;
            operatorSubType <= '0;
            operatorFlag    <= 1'b0;
            robNum          <= '0;
            data1           <= '0;
            data2           <= '0;
            q1              <= INVALID_TAG;
            q2              <= INVALID_TAG;
            offset_out      <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PTR_ONE;
            case (state)
                S_IDLE:  if (!empty) state <= S_ALLOC;
                S_ALLOC: if (rob_alloc_gnt) begin
                    rob_q <= rob_alloc_num;
                    state <= S_READ;
                end
                S_READ: begin
                    {opd_tag1, opd_data1} <= nxt1;
                    {opd_tag2, opd_data2} <= nxt2;
                    state <= S_WAIT;
                end
                S_WAIT: begin
                    {opd_tag1, opd_data1} <= nxt1;
                    {opd_tag2, opd_data2} <= nxt2;
                    // Issue registers load here so they are valid throughout FIRE and hold after.
                    if (available) begin
                        {q1, data1}     <= nxt1;
                        {q2, data2}     <= nxt2;
                        operatorType    <= head.op;
                        operatorSubType <= head.subtype;
                        operatorFlag    <= head.flag;
                        offset_out      <= head.offset;
                        robNum          <= rob_q;
                        state           <= S_FIRE;
                    end
                end
                S_FIRE: begin
                    rd_ptr <= rd_ptr + PTR_ONE;
                    state  <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end
endmodule
